sum_ov_collector: RTL and testbench

SUM_OV_COLLECTOR -- requirements
Module: sum_ov_collector

---
 rtl/sum_ov_collector.sv | 156 +++++++++++++++
 tb/tb_sum_ov_collector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_ov_collector.sv
`default_nettype none
// ============================================================================
// Module   : sum_ov_collector
// Summary  : Small FIFO that queues {ov,sum} adder results and keeps running
//            statistics: total, overflow count and a sticky accumulator-wrap flag.
//            Define SUM_COLLECT_SAT_EN to make the accumulator saturate
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sum_ov_collector #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sum,
    input  logic                     in_ov,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_sum,
    output logic                     out_ov,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ACC_W-1:0]         acc,
    output logic [3:0]               ov_cnt,
    output logic                     acc_wrap
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ACC_W + 1;

    localparam logic [1:0]       c_st_empty = 2'd0;
    localparam logic [1:0]       c_st_part  = 2'd1;
    localparam logic [1:0]       c_st_full  = 2'd2;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
    localparam logic [ACC_W-1:0] c_acc_max  = '1;

    logic [1:0]       state_q,  state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [4:0]       mem_q [DEPTH];
    logic [4:0]       mem_d [DEPTH];
    logic [4:0]       head_q, head_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       ov_cnt_q, ov_cnt_d;
    logic             acc_wrap_q, acc_wrap_d;

    logic             w_accept;
    logic             w_pop;
    logic [4:0]       w_value;
    logic [SUM_W-1:0] w_acc_sum;

    // Handshakes depend only on registered state, never on in_valid/out_ready.
    assign in_ready  = (state_q != c_st_full);
    assign out_valid = (state_q != c_st_empty);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_value   = {in_ov, in_sum};
    assign w_acc_sum = {1'b0, acc_q} + SUM_W'(w_value);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_accept) begin
            mem_d[wr_ptr_q] = w_value;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            state_d = c_st_empty;
        end else if (count_d == c_full_cnt) begin
            state_d = c_st_full;
        end else begin
            state_d = c_st_part;
        end
        // Head register tracks the next entry so it appears one cycle after
        // acceptance, and holds its last value once the FIFO drains.
        head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
    end

    always_comb begin
        acc_d      = acc_q;
        ov_cnt_d   = ov_cnt_q;
        acc_wrap_d = acc_wrap_q;
        if (clr) begin
            acc_wrap_d = 1'b0;
            acc_d      = w_accept ? ACC_W'(w_value) : '0;
            ov_cnt_d   = w_accept ? {3'b000, in_ov} : 4'd0;
        end else if (w_accept) begin
`ifdef SUM_COLLECT_SAT_EN
            if (w_acc_sum[ACC_W] || (w_acc_sum[ACC_W-1:0] == c_acc_max)) begin
                acc_d      = c_acc_max;
                acc_wrap_d = 1'b1;
            end else begin
                acc_d = w_acc_sum[ACC_W-1:0];
            end
`else
            acc_d = w_acc_sum[ACC_W-1:0];
            if (w_acc_sum[ACC_W]) begin
                acc_wrap_d = 1'b1;
            end
`endif
            if (in_ov && (ov_cnt_q != 4'hF)) begin
                ov_cnt_d = ov_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= c_st_empty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            acc_q      <= '0;
            ov_cnt_q   <= '0;
            acc_wrap_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            acc_q      <= acc_d;
            ov_cnt_q   <= ov_cnt_d;
            acc_wrap_q <= acc_wrap_d;
            mem_q      <= mem_d;
        end
    end

    assign out_ov   = head_q[4];
    assign out_sum  = head_q[3:0];
    assign count    = count_q;
    assign acc      = acc_q;
    assign ov_cnt   = ov_cnt_q;
    assign acc_wrap = acc_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_ov_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_ov_collector
// Summary  : Self-checking bench for sum_ov_collector: vector table plus
//            queue scoreboard and reference model of the statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_ov_collector;

    localparam int DEPTH = 4;
    localparam int ACC_W = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_sum = 4'd0;
    logic       in_ov = 1'b0;
    logic       clr = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_sum;
    logic       out_ov;
    logic [$clog2(DEPTH):0] count;
    logic [ACC_W-1:0] acc;
    logic [3:0] ov_cnt;
    logic       acc_wrap;

    sum_ov_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_ov(in_ov),
        .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ov(out_ov),
        .count(count), .acc(acc), .ov_cnt(ov_cnt), .acc_wrap(acc_wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4:0] q[$];
    int  m_acc = 0;
    int  m_ov  = 0;
    bit  m_wrap = 1'b0;

    typedef struct {
        bit       iv;
        bit [3:0] s;
        bit       o;
        bit       ordy;
        bit       c;
        int       exp_count;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock of stimulus: check pre-edge outputs against the scoreboard,
    // update the model, then check post-edge occupancy and statistics.
    task automatic step(input bit iv, input bit [3:0] s, input bit o, input bit ordy, input bit c);
        bit acc_ev, pop_ev;
        logic [4:0] v;
        int sum;
        @(negedge clk);
        in_valid = iv; in_sum = s; in_ov = o; out_ready = ordy; clr = c;
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("head_data", 32'({out_ov, out_sum}), 32'(q[0]));
        v = {o, s};
        acc_ev = iv && (q.size() < DEPTH);
        pop_ev = ordy && (q.size() > 0);
        if (pop_ev) void'(q.pop_front());
        if (acc_ev) q.push_back(v);
        if (c) begin
            m_wrap = 1'b0;
            m_acc  = acc_ev ? int'(v) : 0;
            m_ov   = acc_ev ? int'(o) : 0;
        end else if (acc_ev) begin
            sum = m_acc + int'(v);
`ifdef SUM_COLLECT_SAT_EN
            if (sum >= MAXV) begin
                m_acc = MAXV;
                m_wrap = 1'b1;
            end else begin
                m_acc = sum;
            end
`else
            if (sum > MAXV) m_wrap = 1'b1;
            m_acc = sum & MAXV;
`endif
            if (o && m_ov < 15) m_ov++;
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("acc", 32'(acc), 32'(m_acc));
        chk("ov_cnt", 32'(ov_cnt), 32'(m_ov));
        chk("acc_wrap", 32'(acc_wrap), 32'(m_wrap));
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_sum = 4'd0; in_ov = 1'b0; out_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_acc", 32'(acc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_acc = 0; m_ov = 0; m_wrap = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 3};
        vecs[5]  = '{1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4};
        vecs[6]  = '{1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 4};
        vecs[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3};
        vecs[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2};
        vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 0};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 0};
        vecs[12] = '{1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1};
        vecs[13] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 0};

        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out", 32'({out_ov, out_sum}), 32'd0);
        chk("init_stats", 32'({acc, ov_cnt, acc_wrap}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].iv, vecs[i].s, vecs[i].o, vecs[i].ordy, vecs[i].c);
            chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
            if (i == 0) chk("first_acc", 32'(acc), 32'd5);
        end

        // FULL with a simultaneous pop: the new input must be dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 4'(10 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd14, 1'b0, 1'b1, 1'b0);
        chk("full_pop_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Steady flow at count 2.
        step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(8 + i), i[0], 1'b1, 1'b0);
            chk("steady_count", 32'(count), 32'd2);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset discards entries; next accept is seen at head.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(1 + i), 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        chk("post_rst_head", 32'(out_sum), 32'd7);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Accumulator wrap / saturation.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
`ifdef SUM_COLLECT_SAT_EN
        chk("acc_9x31", 32'(acc), 32'd255);
`else
        chk("acc_9x31", 32'(acc), 32'd23);
`endif
        chk("wrap_9x31", 32'(acc_wrap), 32'd1);
        chk("ov_cnt_9", 32'(ov_cnt), 32'd9);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // ov_cnt saturation, then clr racing an accept.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("ov_cnt_sat", 32'(ov_cnt), 32'd15);
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        chk("clr_acc", 32'(acc), 32'd19);
        chk("clr_ov_cnt", 32'(ov_cnt), 32'd1);
        chk("clr_wrap", 32'(acc_wrap), 32'd0);
        chk("clr_count", 32'(count), 32'd2);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_only_acc", 32'(acc), 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
